// File: rtl/instruction_fetch_pkg.sv
// Shared definitions for the fetch stage: state encoding, instruction width,
// bubble encoding and the PC step.
package instruction_fetch_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_e;

  localparam int unsigned INSTR_W  = 16;
  localparam logic [15:0] NOP_INSTR = 16'h0000;
  localparam logic [15:0] PC_INC    = 16'd2;

endpackage

// File: rtl/instruction_fetch_if_id_reg.sv
// IF/ID pipeline register: flush inserts a bubble, hold freezes the contents,
// otherwise the fetched instruction and its PC+2 are captured.
module if_id_reg
  import instruction_fetch_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               hold_i,
  input  logic               flush_i,
  input  logic [INSTR_W-1:0] instr_i,
  input  logic [15:0]        pc_plus2_i,
  output logic [INSTR_W-1:0] instr_o,
  output logic [15:0]        pc_plus2_o,
  output logic               valid_o
);

  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [15:0]        pc_plus2_q, pc_plus2_d;
  logic               valid_q, valid_d;

  always_comb begin
    instr_d    = instr_q;
    pc_plus2_d = pc_plus2_q;
    valid_d    = valid_q;
    if (flush_i) begin
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
    end else if (!hold_i) begin
      instr_d    = instr_i;
      pc_plus2_d = pc_plus2_i;
      valid_d    = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_q    <= NOP_INSTR;
      pc_plus2_q <= 16'h0000;
      valid_q    <= 1'b0;
    end else begin
      instr_q    <= instr_d;
      pc_plus2_q <= pc_plus2_d;
      valid_q    <= valid_d;
    end
  end

  assign instr_o    = instr_q;
  assign pc_plus2_o = pc_plus2_q;
  assign valid_o    = valid_q;

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: PC and BOOT/RUN/HALT control with stall, branch/exception
// redirect and sticky fault detection on the current PC.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter int unsigned N          = 100,
  parameter logic [15:0] EXC_VECTOR = 16'h0040
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               branch_taken,
  input  logic [15:0]        branch_target,
  input  logic               exc_req,
  output logic [15:0]        ReadAddress,
  input  logic [INSTR_W-1:0] Instruction,
  output logic [INSTR_W-1:0] ifid_instr,
  output logic [15:0]        ifid_pc_plus2,
  output logic               ifid_valid,
  output logic               fetch_fault,
  output logic               halted
);

  localparam logic [15:0] PC_MAX = 16'(N - 2);

  fetch_state_e state_q, state_d;
  logic [15:0]  pc_q, pc_d;
  logic         fault_q, fault_d;
  logic         halted_q, halted_d;
  logic         hold_s, flush_s;
  logic         bad_pc_s;
  logic [15:0]  pc_plus2_s;

  assign pc_plus2_s = pc_q + PC_INC;
  // Redirect targets are only checked once they become the PC, so one check covers all paths.
  assign bad_pc_s   = (pc_q > PC_MAX) || pc_q[0];

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    fault_d = fault_q;
    hold_s  = 1'b0;
    flush_s = 1'b0;
    case (state_q)
      BOOT: begin
        hold_s  = 1'b1;
        state_d = RUN;
      end
      RUN: begin
        if (bad_pc_s) begin
          fault_d = 1'b1;
          flush_s = 1'b1;
          state_d = HALT;
        end else if (exc_req) begin
          pc_d    = EXC_VECTOR;
          flush_s = 1'b1;
        end else if (branch_taken) begin
          pc_d    = branch_target;
          flush_s = 1'b1;
        end else if (stall) begin
          hold_s = 1'b1;
        end else begin
          pc_d = pc_plus2_s;
        end
      end
      HALT: begin
        hold_s = 1'b1;
      end
      default: begin
        hold_s  = 1'b1;
        state_d = HALT;
      end
    endcase
    halted_d = (state_d == HALT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= BOOT;
      pc_q     <= 16'h0000;
      fault_q  <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      fault_q  <= fault_d;
      halted_q <= halted_d;
    end
  end

  if_id_reg u_if_id (
    .clk        (clk),
    .rst        (rst),
    .hold_i     (hold_s),
    .flush_i    (flush_s),
    .instr_i    (Instruction),
    .pc_plus2_i (pc_plus2_s),
    .instr_o    (ifid_instr),
    .pc_plus2_o (ifid_pc_plus2),
    .valid_o    (ifid_valid)
  );

  assign ReadAddress = pc_q;
  assign fetch_fault = fault_q;
  assign halted      = halted_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed vector table, hand-written
// reset/fault sequences and a randomized run against a behavioural model.
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic        exc_req = 1'b0;
  logic [15:0] branch_target = 16'h0000;
  logic [15:0] ReadAddress;
  logic [15:0] Instruction;
  logic [15:0] ifid_instr;
  logic [15:0] ifid_pc_plus2;
  logic        ifid_valid;
  logic        fetch_fault;
  logic        halted;

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] mem [0:49];

  instruction_fetch dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .exc_req       (exc_req),
    .ReadAddress   (ReadAddress),
    .Instruction   (Instruction),
    .ifid_instr    (ifid_instr),
    .ifid_pc_plus2 (ifid_pc_plus2),
    .ifid_valid    (ifid_valid),
    .fetch_fault   (fetch_fault),
    .halted        (halted)
  );

  always #5 clk = ~clk;

  // Combinational instruction memory: 100 bytes, out-of-range reads return a marker.
  assign Instruction = (ReadAddress < 16'd100 && !ReadAddress[0]) ? mem[ReadAddress[6:1]] : 16'hDEAD;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    if (a < 16'd100 && !a[0]) return mem[a[6:1]];
    return 16'hDEAD;
  endfunction

  // Behavioural model of the fetch stage, stepped once per clock edge.
  logic [15:0] m_pc, m_instr, m_pc2;
  bit          m_valid, m_fault, m_halted, m_running;

  task automatic model_reset();
    m_pc = 16'h0000; m_instr = 16'h0000; m_pc2 = 16'h0000;
    m_valid = 1'b0; m_fault = 1'b0; m_halted = 1'b0; m_running = 1'b0;
  endtask

  task automatic model_edge(input logic s, input logic b, input logic e, input logic [15:0] t);
    if (m_halted) begin
      // frozen until reset
    end else if (!m_running) begin
      m_running = 1'b1;
    end else if (m_pc > 16'd98 || m_pc[0]) begin
      m_fault = 1'b1; m_halted = 1'b1; m_valid = 1'b0;
    end else if (e) begin
      m_pc = 16'h0040; m_valid = 1'b0;
    end else if (b) begin
      m_pc = t; m_valid = 1'b0;
    end else if (s) begin
      // IF/ID and PC held
    end else begin
      m_instr = mem_word(m_pc);
      m_pc2   = m_pc + 16'd2;
      m_pc    = m_pc + 16'd2;
      m_valid = 1'b1;
    end
  endtask

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic step(input logic s, input logic b, input logic e, input logic [15:0] t);
    stall = s; branch_taken = b; exc_req = e; branch_target = t;
    @(posedge clk);
    #1;
    model_edge(s, b, e, t);
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_addr"}, ReadAddress, m_pc);
    chk1({tag, "_valid"}, ifid_valid, m_valid);
    chk1({tag, "_fault"}, fetch_fault, m_fault);
    chk1({tag, "_halted"}, halted, m_halted);
    if (m_valid) begin
      chk({tag, "_instr"}, ifid_instr, m_instr);
      chk({tag, "_pc2"}, ifid_pc_plus2, m_pc2);
    end
  endtask

  task automatic do_reset(input string tag);
    stall = 1'b0; branch_taken = 1'b0; exc_req = 1'b0; branch_target = 16'h0000;
    rst = 1'b1;
    #1;
    model_reset();
    chk({tag, "_rst_addr"}, ReadAddress, 16'h0000);
    chk({tag, "_rst_instr"}, ifid_instr, 16'h0000);
    chk({tag, "_rst_pc2"}, ifid_pc_plus2, 16'h0000);
    chk1({tag, "_rst_valid"}, ifid_valid, 1'b0);
    chk1({tag, "_rst_fault"}, fetch_fault, 1'b0);
    chk1({tag, "_rst_halted"}, halted, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  typedef struct {
    logic        s;
    logic        b;
    logic        e;
    logic [15:0] t;
    logic [15:0] addr;
    logic        v;
    logic [15:0] instr;
    logic [15:0] pc2;
    logic        f;
    logic        h;
  } vec_t;

  vec_t tbl [15];

  initial begin
    for (int i = 0; i < 50; i++) mem[i] = 16'hA000 | 16'(i);
    mem[0]  = 16'h1120;
    mem[1]  = 16'h12D1;
    mem[2]  = 16'h148E;
    mem[15] = 16'h1110;

    //            s     b     e     target    addr      v     instr     pc2       f     h
    tbl[0]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 16'h0002, 1'b1, 16'h1120, 16'h0002, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 16'h0004, 1'b1, 16'h12D1, 16'h0004, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 16'h0004, 1'b1, 16'h12D1, 16'h0004, 1'b0, 1'b0};
    tbl[4]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 16'h0004, 1'b1, 16'h12D1, 16'h0004, 1'b0, 1'b0};
    tbl[5]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 16'h0004, 1'b1, 16'h12D1, 16'h0004, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 16'h0006, 1'b1, 16'h148E, 16'h0006, 1'b0, 1'b0};
    tbl[7]  = '{1'b1, 1'b1, 1'b0, 16'h0016, 16'h0016, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 1'b1, 1'b0, 16'h001E, 16'h001E, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 16'h0020, 1'b1, 16'h1110, 16'h0020, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 1'b1, 1'b1, 16'h0002, 16'h0040, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0};
    tbl[11] = '{1'b0, 1'b0, 1'b0, 16'h0000, 16'h0042, 1'b1, 16'hA020, 16'h0042, 1'b0, 1'b0};
    tbl[12] = '{1'b0, 1'b1, 1'b0, 16'h0063, 16'h0063, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0};
    tbl[13] = '{1'b0, 1'b0, 1'b0, 16'h0000, 16'h0063, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b1};
    tbl[14] = '{1'b1, 1'b1, 1'b1, 16'h0010, 16'h0063, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b1};

    #2;
    do_reset("init");
    for (int i = 0; i < 15; i++) begin
      step(tbl[i].s, tbl[i].b, tbl[i].e, tbl[i].t);
      chk($sformatf("vec%0d_addr", i), ReadAddress, tbl[i].addr);
      chk1($sformatf("vec%0d_valid", i), ifid_valid, tbl[i].v);
      chk1($sformatf("vec%0d_fault", i), fetch_fault, tbl[i].f);
      chk1($sformatf("vec%0d_halted", i), halted, tbl[i].h);
      if (tbl[i].v) begin
        chk($sformatf("vec%0d_instr", i), ifid_instr, tbl[i].instr);
        chk($sformatf("vec%0d_pc2", i), ifid_pc_plus2, tbl[i].pc2);
      end
    end

    // Out-of-range redirect target faults on the following cycle and freezes.
    do_reset("oor");
    step(1'b0, 1'b0, 1'b0, 16'h0000);
    step(1'b0, 1'b1, 1'b0, 16'h0064);
    chk("oor_redirect_addr", ReadAddress, 16'h0064);
    chk1("oor_redirect_fault", fetch_fault, 1'b0);
    step(1'b0, 1'b0, 1'b0, 16'h0000);
    chk1("oor_fault", fetch_fault, 1'b1);
    chk1("oor_halted", halted, 1'b1);
    chk("oor_frozen_addr", ReadAddress, 16'h0064);
    step(1'b0, 1'b1, 1'b0, 16'h0002);
    chk("oor_branch_ignored", ReadAddress, 16'h0064);

    // Asynchronous reset in the middle of a stall while halted with the fault flag set.
    stall = 1'b1;
    @(negedge clk);
    do_reset("midstall");
    step(1'b0, 1'b0, 1'b0, 16'h0000);
    chk("boot_addr", ReadAddress, 16'h0000);
    chk1("boot_valid", ifid_valid, 1'b0);
    step(1'b0, 1'b0, 1'b0, 16'h0000);
    chk("restart_addr", ReadAddress, 16'h0002);
    chk1("restart_valid", ifid_valid, 1'b1);
    chk("restart_instr", ifid_instr, 16'h1120);

    // Randomized run against the model; halts are left by a reset after a few frozen cycles.
    do_reset("rand");
    for (int i = 0; i < 800; i++) begin
      logic        rs, rb, re;
      logic [15:0] rt;
      if (m_halted && $urandom_range(0, 3) == 0) begin
        do_reset($sformatf("rand%0d", i));
      end else begin
        rs = ($urandom_range(0, 3) == 0);
        rb = ($urandom_range(0, 9) == 0);
        re = ($urandom_range(0, 19) == 0);
        rt = ($urandom_range(0, 7) == 0) ? 16'($urandom_range(0, 200)) : 16'($urandom_range(0, 49) * 2);
        step(rs, rb, re, rt);
        check_model($sformatf("rand%0d", i));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
